// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Multi-cycle MIPS control unit. Sequences each instruction over
//               3-5 cycles (FETCH, DECODE, execute, memory, write-back) for a
//               shared-memory datapath, stalling FETCH / MEM_READ / MEM_WRITE
//               on a memory-ready handshake. Unknown opcodes halt the machine
//               until reset. Counts retired instructions.
// Ports       : clk, reset (async, active-low)
//               opcode_i     - IR[31:26], sampled in DECODE
//               mem_ready_i  - memory access completes this cycle
//               *_o          - datapath strobes/selects, alu_op_o,
//                              illegal_o (sticky), instr_count_o
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int ALU_OP_WIDTH = 3,
    parameter int CNT_WIDTH    = 32,
    parameter int MEM_WAIT_EN  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [5:0]              opcode_i,
    input  logic                    mem_ready_i,
    output logic                    pc_write_o,
    output logic                    ir_write_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    i_or_d_o,
    output logic                    alu_src_a_o,
    output logic                    reg_write_o,
    output logic                    branch_eq_o,
    output logic                    branch_ne_o,
    output logic [1:0]              alu_src_b_o,
    output logic [1:0]              reg_dst_o,
    output logic [1:0]              mem_to_reg_o,
    output logic [1:0]              pc_src_o,
    output logic [ALU_OP_WIDTH-1:0] alu_op_o,
    output logic                    illegal_o,
    output logic [CNT_WIDTH-1:0]    instr_count_o
);

    // Opcodes
    localparam logic [5:0] c_op_r    = 6'h00;
    localparam logic [5:0] c_op_addi = 6'h08;
    localparam logic [5:0] c_op_ori  = 6'h0D;
    localparam logic [5:0] c_op_andi = 6'h0C;
    localparam logic [5:0] c_op_lui  = 6'h0F;
    localparam logic [5:0] c_op_lw   = 6'h23;
    localparam logic [5:0] c_op_sw   = 6'h2B;
    localparam logic [5:0] c_op_beq  = 6'h04;
    localparam logic [5:0] c_op_bne  = 6'h05;
    localparam logic [5:0] c_op_j    = 6'h02;
    localparam logic [5:0] c_op_jal  = 6'h03;

    // ALU operation codes, zero-extended to the port width
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_add = ALU_OP_WIDTH'(3'b100);
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_or  = ALU_OP_WIDTH'(3'b001);
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_r   = ALU_OP_WIDTH'(3'b111);
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_sub = ALU_OP_WIDTH'(3'b010);
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_and = ALU_OP_WIDTH'(3'b011);
    localparam logic [ALU_OP_WIDTH-1:0] c_alu_lui = ALU_OP_WIDTH'(3'b101);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_EXEC_R    = 4'd3,
        ST_EXEC_I    = 4'd4,
        ST_ALU_WB    = 4'd5,
        ST_MEM_ADDR  = 4'd6,
        ST_MEM_READ  = 4'd7,
        ST_MEM_WB    = 4'd8,
        ST_MEM_WRITE = 4'd9,
        ST_BRANCH    = 4'd10,
        ST_JUMP      = 4'd11,
        ST_HALT      = 4'd12
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             opcode_q, opcode_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   w_ready;
    logic                   w_retire;

    // With waits disabled the handshake is treated as permanently ready.
    assign w_ready = (MEM_WAIT_EN != 0) ? mem_ready_i : 1'b1;

    // ------------------------------------------------------------------
    // State, opcode and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            opcode_q <= 6'h00;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state, opcode capture and retire counting
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        w_retire = 1'b0;

        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (w_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                // The live IR opcode steers this transition and is captured
                // so later states are immune to IR changes.
                opcode_d = opcode_i;
                case (opcode_i)
                    c_op_r:                                  state_d = ST_EXEC_R;
                    c_op_addi, c_op_ori, c_op_andi, c_op_lui: state_d = ST_EXEC_I;
                    c_op_lw, c_op_sw:                        state_d = ST_MEM_ADDR;
                    c_op_beq, c_op_bne:                      state_d = ST_BRANCH;
                    c_op_j, c_op_jal:                        state_d = ST_JUMP;
                    default:                                 state_d = ST_HALT;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_ALU_WB;
            ST_MEM_ADDR: state_d = (opcode_q == c_op_lw) ? ST_MEM_READ : ST_MEM_WRITE;
            ST_MEM_READ: if (w_ready) state_d = ST_MEM_WB;
            ST_MEM_WRITE: begin
                if (w_ready) begin
                    state_d  = ST_FETCH;
                    w_retire = 1'b1;
                end
            end
            ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP: begin
                state_d  = ST_FETCH;
                w_retire = 1'b1;
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase

        count_d = w_retire ? (count_q + CNT_WIDTH'(1)) : count_q;
    end

    // ------------------------------------------------------------------
    // Outputs: Moore per state, except the FETCH strobes which follow
    // mem_ready_i so PC and IR load exactly once, in the ready cycle.
    // ------------------------------------------------------------------
    always_comb begin
        pc_write_o   = 1'b0;
        ir_write_o   = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        i_or_d_o     = 1'b0;
        alu_src_a_o  = 1'b0;
        reg_write_o  = 1'b0;
        branch_eq_o  = 1'b0;
        branch_ne_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        reg_dst_o    = 2'b00;
        mem_to_reg_o = 2'b00;
        pc_src_o     = 2'b00;
        alu_op_o     = '0;
        illegal_o    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'b01;
                alu_op_o    = c_alu_add;
                ir_write_o  = w_ready;
                pc_write_o  = w_ready;
            end
            ST_DECODE: begin
                alu_src_b_o = 2'b11;
                alu_op_o    = c_alu_add;
            end
            ST_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_alu_r;
            end
            ST_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_q)
                    c_op_ori:  alu_op_o = c_alu_or;
                    c_op_andi: alu_op_o = c_alu_and;
                    c_op_lui:  alu_op_o = c_alu_lui;
                    default:   alu_op_o = c_alu_add;
                endcase
            end
            ST_ALU_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = (opcode_q == c_op_r) ? 2'b01 : 2'b00;
            end
            ST_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                alu_op_o    = c_alu_add;
            end
            ST_MEM_READ: begin
                mem_read_o = 1'b1;
                i_or_d_o   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 2'b01;
            end
            ST_MEM_WRITE: begin
                mem_write_o = 1'b1;
                i_or_d_o    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = c_alu_sub;
                pc_src_o    = 2'b01;
                branch_eq_o = (opcode_q == c_op_beq);
                branch_ne_o = (opcode_q == c_op_bne);
            end
            ST_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
                if (opcode_q == c_op_jal) begin
                    reg_write_o  = 1'b1;
                    reg_dst_o    = 2'b10;
                    mem_to_reg_o = 2'b10;
                end
            end
            ST_HALT:  illegal_o = 1'b1;
            default: ;
        endcase
    end

    assign instr_count_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control. A per-cycle table
//               of {opcode, mem_ready, expected outputs, expected count} walks
//               every instruction class, stalls and HALT; hand sequences cover
//               async reset in HALT and mid-MEM_WRITE, counter wrap with
//               CNT_WIDTH=4 and MEM_WAIT_EN=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       rdy;

    always #5 clk = ~clk;

    // Three instances share stimulus: default, 4-bit counter, waits disabled.
    logic        pcw [3], irw [3], mr [3], mw [3], iod [3], asa [3], rw [3], beq [3], bne [3], ill [3];
    logic [1:0]  asb [3], rd [3], m2r [3], pcs [3];
    logic [2:0]  aop [3];
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [31:0] cnt2;

    multicycle_control #(.ALU_OP_WIDTH(3), .CNT_WIDTH(32), .MEM_WAIT_EN(1)) dut (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(rdy),
        .pc_write_o(pcw[0]), .ir_write_o(irw[0]), .mem_read_o(mr[0]), .mem_write_o(mw[0]),
        .i_or_d_o(iod[0]), .alu_src_a_o(asa[0]), .reg_write_o(rw[0]),
        .branch_eq_o(beq[0]), .branch_ne_o(bne[0]), .alu_src_b_o(asb[0]), .reg_dst_o(rd[0]),
        .mem_to_reg_o(m2r[0]), .pc_src_o(pcs[0]), .alu_op_o(aop[0]), .illegal_o(ill[0]),
        .instr_count_o(cnt0));

    multicycle_control #(.ALU_OP_WIDTH(3), .CNT_WIDTH(4), .MEM_WAIT_EN(1)) dut4 (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(rdy),
        .pc_write_o(pcw[1]), .ir_write_o(irw[1]), .mem_read_o(mr[1]), .mem_write_o(mw[1]),
        .i_or_d_o(iod[1]), .alu_src_a_o(asa[1]), .reg_write_o(rw[1]),
        .branch_eq_o(beq[1]), .branch_ne_o(bne[1]), .alu_src_b_o(asb[1]), .reg_dst_o(rd[1]),
        .mem_to_reg_o(m2r[1]), .pc_src_o(pcs[1]), .alu_op_o(aop[1]), .illegal_o(ill[1]),
        .instr_count_o(cnt1));

    multicycle_control #(.ALU_OP_WIDTH(3), .CNT_WIDTH(32), .MEM_WAIT_EN(0)) dut_nw (
        .clk(clk), .reset(reset), .opcode_i(opcode), .mem_ready_i(rdy),
        .pc_write_o(pcw[2]), .ir_write_o(irw[2]), .mem_read_o(mr[2]), .mem_write_o(mw[2]),
        .i_or_d_o(iod[2]), .alu_src_a_o(asa[2]), .reg_write_o(rw[2]),
        .branch_eq_o(beq[2]), .branch_ne_o(bne[2]), .alu_src_b_o(asb[2]), .reg_dst_o(rd[2]),
        .mem_to_reg_o(m2r[2]), .pc_src_o(pcs[2]), .alu_op_o(aop[2]), .illegal_o(ill[2]),
        .instr_count_o(cnt2));

    // Output bundle order:
    // pcw irw mr mw iod asa rw beq bne | asb rd m2r pcs | aop | ill
    function automatic logic [20:0] outs(input int k);
        return {pcw[k], irw[k], mr[k], mw[k], iod[k], asa[k], rw[k], beq[k], bne[k],
                asb[k], rd[k], m2r[k], pcs[k], aop[k], ill[k]};
    endfunction

    function automatic logic [20:0] pk(
        input logic pw, iw, r, w, id, sa, wr, be, bn,
        input logic [1:0] sb, dst, mtr, ps,
        input logic [2:0] op, input logic il);
        return {pw, iw, r, w, id, sa, wr, be, bn, sb, dst, mtr, ps, op, il};
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [20:0] exp;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [20:0] O_IDLE, O_FE, O_FS, O_DEC, O_EXR, O_EXI_ADD, O_EXI_OR, O_EXI_AND, O_EXI_LUI;
    logic [20:0] O_WBR, O_WBI, O_MA, O_MR, O_MWB, O_MW, O_BEQ, O_BNE, O_J, O_JAL, O_HALT;

    localparam logic [5:0] X = 6'h3F;   // IR contents outside DECODE: must be ignored

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic add(input logic [5:0] op, input logic r, input logic [20:0] e, input logic [31:0] c);
        vec_t v;
        v.op = op; v.rdy = r; v.exp = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    initial begin
        //         pw iw r  w  id sa wr be bn sb     dst    mtr    ps     op      il
        O_IDLE    = '0;
        O_FE      = pk(1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 0);
        O_FS      = pk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3'b100, 0);
        O_DEC     = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 3'b100, 0);
        O_EXR     = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b111, 0);
        O_EXI_ADD = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b100, 0);
        O_EXI_OR  = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 0);
        O_EXI_AND = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b011, 0);
        O_EXI_LUI = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b101, 0);
        O_WBR     = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, 3'b000, 0);
        O_WBI     = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        O_MA      = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 2'b00, 2'b00, 2'b00, 3'b100, 0);
        O_MR      = pk(0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        O_MWB     = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 0);
        O_MW      = pk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0);
        O_BEQ     = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 0);
        O_BNE     = pk(0, 0, 0, 0, 0, 1, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b01, 3'b010, 0);
        O_J       = pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b10, 3'b000, 0);
        O_JAL     = pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b10, 2'b10, 2'b10, 3'b000, 0);
        O_HALT    = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1);

        // R-type, zero wait
        add(X, 1, O_IDLE, 0);   add(X, 1, O_FE, 0);    add(6'h00, 1, O_DEC, 0);
        add(X, 1, O_EXR, 0);    add(X, 1, O_WBR, 0);
        // ORI
        add(X, 1, O_FE, 1);     add(6'h0D, 1, O_DEC, 1);
        add(X, 1, O_EXI_OR, 1); add(X, 1, O_WBI, 1);
        // FETCH stalled 3 cycles, then LW with MEM_READ stalled 2 cycles
        add(X, 0, O_FS, 2);     add(X, 0, O_FS, 2);    add(X, 0, O_FS, 2);
        add(X, 1, O_FE, 2);     add(6'h23, 0, O_DEC, 2);
        add(X, 0, O_MA, 2);     add(X, 0, O_MR, 2);    add(X, 0, O_MR, 2);
        add(X, 1, O_MR, 2);     add(X, 1, O_MWB, 2);
        // BNE (ready low outside memory states must not stall)
        add(X, 1, O_FE, 3);     add(6'h05, 0, O_DEC, 3); add(X, 0, O_BNE, 3);
        // JAL
        add(X, 1, O_FE, 4);     add(6'h03, 1, O_DEC, 4); add(X, 1, O_JAL, 4);
        // SW with one wait cycle
        add(X, 1, O_FE, 5);     add(6'h2B, 1, O_DEC, 5);
        add(X, 1, O_MA, 5);     add(X, 0, O_MW, 5);    add(X, 1, O_MW, 5);
        // BEQ
        add(X, 1, O_FE, 6);     add(6'h04, 1, O_DEC, 6); add(X, 1, O_BEQ, 6);
        // ANDI
        add(X, 1, O_FE, 7);     add(6'h0C, 1, O_DEC, 7);
        add(X, 1, O_EXI_AND, 7); add(X, 1, O_WBI, 7);
        // LUI
        add(X, 1, O_FE, 8);     add(6'h0F, 1, O_DEC, 8);
        add(X, 1, O_EXI_LUI, 8); add(X, 1, O_WBI, 8);
        // ADDI
        add(X, 1, O_FE, 9);     add(6'h08, 1, O_DEC, 9);
        add(X, 1, O_EXI_ADD, 9); add(X, 1, O_WBI, 9);
        // J
        add(X, 1, O_FE, 10);    add(6'h02, 1, O_DEC, 10); add(X, 1, O_J, 10);
        // Illegal opcode -> HALT for 10 cycles regardless of inputs
        add(X, 1, O_FE, 11);    add(6'h3F, 1, O_DEC, 11);
        for (int i = 0; i < 10; i++) add(6'h00, 1'(i % 2), O_HALT, 11);

        // ---------------- reset ----------------
        reset = 1'b0; opcode = 6'h00; rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {11'd0, outs(0)}, 32'd0);
        check("reset_cnt", cnt0, 32'd0);
        reset = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++) begin
            opcode = vecs[i].op;
            rdy    = vecs[i].rdy;
            @(negedge clk);
            check($sformatf("row%0d_outs", i), {11'd0, outs(0)}, {11'd0, vecs[i].exp});
            check($sformatf("row%0d_cnt", i), cnt0, vecs[i].cnt);
            @(posedge clk);
            #1;
        end

        // ---------------- async reset out of HALT ----------------
        reset = 1'b0;
        #1;
        check("halt_rst_outs", {11'd0, outs(0)}, 32'd0);
        check("halt_rst_illegal", {31'd0, ill[0]}, 32'd0);
        check("halt_rst_cnt", cnt0, 32'd0);

        // ---------------- 17 ADDI, counter wrap on 4-bit instance ----------------
        @(posedge clk);
        #1;
        opcode = 6'h08; rdy = 1'b1; reset = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {11'd0, outs(0)}, 32'd0);
        repeat (69) @(posedge clk);
        @(negedge clk);
        check("wrap_fetch_outs", {11'd0, outs(0)}, {11'd0, O_FE});
        check("wrap_cnt32", cnt0, 32'd17);
        check("wrap_cnt4", {28'd0, cnt1}, 32'd1);
        check("wrap_cnt_nowait", cnt2, 32'd17);

        // ---------------- reset mid-MEM_WRITE ----------------
        @(posedge clk); #1; opcode = 6'h2B;
        @(posedge clk); #1; opcode = X;
        @(posedge clk); #1; rdy = 1'b0;
        @(negedge clk);
        check("sw_stall_outs", {11'd0, outs(0)}, {11'd0, O_MW});
        #2;
        reset = 1'b0;
        #1;
        check("sw_rst_mem_write", {31'd0, mw[0]}, 32'd0);
        check("sw_rst_outs", {11'd0, outs(0)}, 32'd0);
        check("sw_rst_cnt", cnt0, 32'd0);

        // ---------------- MEM_WAIT_EN=0 ignores mem_ready_i ----------------
        opcode = 6'h00; rdy = 1'b0;
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("nowait_fetch", {11'd0, outs(2)}, {11'd0, O_FE});
        check("wait_fetch_stall", {11'd0, outs(0)}, {11'd0, O_FS});
        @(posedge clk);
        @(negedge clk);
        check("nowait_decode", {11'd0, outs(2)}, {11'd0, O_DEC});
        check("wait_still_stall", {11'd0, outs(0)}, {11'd0, O_FS});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
